// File: rtl/lvds_panel_sequencer_pkg.sv
// lvds_panel_sequencer_pkg: state encodings, default delays and output decode helpers
package lvds_panel_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_VDD_UP    = 3'd1,
        ST_LVDS_UP   = 3'd2,
        ST_ON        = 3'd3,
        ST_BL_DOWN   = 3'd4,
        ST_LVDS_DOWN = 3'd5,
        ST_VDD_DOWN  = 3'd6
    } state_e;

    localparam int DEF_CW         = 24;
    localparam int DEF_T_VDD_LVDS = 16;
    localparam int DEF_T_LVDS_BL  = 16;
    localparam int DEF_T_BL_LVDS  = 16;
    localparam int DEF_T_LVDS_VDD = 16;
    localparam int DEF_T_OFF      = 64;

    // Panel supply stays up in every state between power-up and supply teardown
    function automatic logic vdd_on(state_e s);
        return s inside {ST_VDD_UP, ST_LVDS_UP, ST_ON, ST_BL_DOWN, ST_LVDS_DOWN};
    endfunction

    // Serializers run from LVDS power-up until the backlight has been off long enough
    function automatic logic lvds_on(state_e s);
        return s inside {ST_LVDS_UP, ST_ON, ST_BL_DOWN};
    endfunction

    function automatic logic bl_on(state_e s);
        return s == ST_ON;
    endfunction

endpackage

// File: rtl/lvds_panel_sequencer_seq_timer.sv
// seq_timer: loadable down-counter that parks at zero
module seq_timer #(
    parameter int CW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] value,
    output logic          zero
);

    logic [CW-1:0] cnt_q;

    // Load wins over counting; the count holds once it reaches zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else if (load)
            cnt_q <= load_val;
        else if (cnt_q != '0)
            cnt_q <= cnt_q - CW'(1);
    end

    assign value = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/lvds_panel_sequencer.sv
// lvds_panel_sequencer: orders panel VDD, LVDS and backlight enables with timed up/down sequencing
module lvds_panel_sequencer
    import lvds_panel_sequencer_pkg::*;
#(
    parameter int CW         = DEF_CW,
    parameter int T_VDD_LVDS = DEF_T_VDD_LVDS,
    parameter int T_LVDS_BL  = DEF_T_LVDS_BL,
    parameter int T_BL_LVDS  = DEF_T_BL_LVDS,
    parameter int T_LVDS_VDD = DEF_T_LVDS_VDD,
    parameter int T_OFF      = DEF_T_OFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       pll_locked,
    input  logic       vsync,
    output logic       panel_vdd_en,
    output logic       lvds_en,
    output logic       bl_en,
    output logic       blank,
    output logic       ready,
    output logic [2:0] state
);

    state_e        state_q, state_d;
    logic          blank_q, blank_d;
    logic          vsync_q;
    logic          vdd_q, lvds_q, bl_q, ready_q;
    logic          shutdown;
    logic          timer_load;
    logic [CW-1:0] timer_val;
    logic [CW-1:0] unused_timer_value;
    logic          timer_zero;

    // Each timed state is loaded with T-1 so it exits after exactly T cycles
    function automatic logic [CW-1:0] entry_delay(state_e s);
        case (s)
            ST_VDD_UP:    return CW'(T_VDD_LVDS - 1);
            ST_LVDS_UP:   return CW'(T_LVDS_BL - 1);
            ST_BL_DOWN:   return CW'(T_BL_LVDS - 1);
            ST_LVDS_DOWN: return CW'(T_LVDS_VDD - 1);
            ST_VDD_DOWN:  return CW'(T_OFF - 1);
            default:      return '0;
        endcase
    endfunction

    seq_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .value    (unused_timer_value),
        .zero     (timer_zero)
    );

    assign shutdown = !enable || !pll_locked;

    // Next state: shutdown beats timer expiry on the up path; down path always runs to OFF
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:       state_d = (enable && pll_locked) ? ST_VDD_UP : ST_OFF;
            ST_VDD_UP:    state_d = shutdown ? ST_VDD_DOWN : timer_zero ? ST_LVDS_UP : ST_VDD_UP;
            ST_LVDS_UP:   state_d = shutdown ? ST_LVDS_DOWN : timer_zero ? ST_ON : ST_LVDS_UP;
            ST_ON:        state_d = shutdown ? ST_BL_DOWN : ST_ON;
            ST_BL_DOWN:   state_d = timer_zero ? ST_LVDS_DOWN : ST_BL_DOWN;
            ST_LVDS_DOWN: state_d = timer_zero ? ST_VDD_DOWN : ST_LVDS_DOWN;
            ST_VDD_DOWN:  state_d = timer_zero ? ST_OFF : ST_VDD_DOWN;
            default:      state_d = ST_OFF;
        endcase
        timer_load = (state_d != state_q);
        timer_val  = entry_delay(state_d);
        blank_d    = (state_d != ST_ON) ? 1'b1 :
                     (state_q == ST_ON && vsync && !vsync_q) ? 1'b0 : blank_q;
    end

    // vsync_q holds the level sampled at the previous edge, so a level already high on ON entry is not an edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_OFF;
            blank_q <= 1'b1;
            vsync_q <= 1'b0;
            vdd_q   <= 1'b0;
            lvds_q  <= 1'b0;
            bl_q    <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            blank_q <= blank_d;
            vsync_q <= vsync;
            vdd_q   <= vdd_on(state_d);
            lvds_q  <= lvds_on(state_d);
            bl_q    <= bl_on(state_d);
            ready_q <= (state_d == ST_ON) && !blank_d;
        end
    end

    assign panel_vdd_en = vdd_q;
    assign lvds_en      = lvds_q;
    assign bl_en        = bl_q;
    assign blank        = blank_q;
    assign ready        = ready_q;
    assign state        = state_q;

endmodule

// File: tb/tb_lvds_panel_sequencer.sv
// tb_lvds_panel_sequencer: directed and random checks against a phase/age reference model
module tb_lvds_panel_sequencer;

    localparam int T1 = 4;
    localparam int T2 = 6;
    localparam int T3 = 3;
    localparam int T4 = 5;
    localparam int T5 = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       pll_locked = 1'b0;
    logic       vsync = 1'b0;
    logic       panel_vdd_en, lvds_en, bl_en, blank, ready;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    int ph = 0;
    int age = 0;
    bit mblank = 1'b1;
    bit prev_v = 1'b0;

    always #5 clk = ~clk;

    lvds_panel_sequencer #(
        .CW(24), .T_VDD_LVDS(T1), .T_LVDS_BL(T2), .T_BL_LVDS(T3), .T_LVDS_VDD(T4), .T_OFF(T5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .pll_locked   (pll_locked),
        .vsync        (vsync),
        .panel_vdd_en (panel_vdd_en),
        .lvds_en      (lvds_en),
        .bl_en        (bl_en),
        .blank        (blank),
        .ready        (ready),
        .state        (state)
    );

    function automatic int dur(int p);
        case (p)
            1: return T1;
            2: return T2;
            4: return T3;
            5: return T4;
            6: return T5;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        ph = 0;
        age = 0;
        mblank = 1'b1;
        prev_v = 1'b0;
    endtask

    task automatic model_edge();
        bit sd;
        int nph;
        sd = !enable || !pll_locked;
        nph = ph;
        case (ph)
            0: if (enable && pll_locked) nph = 1;
            1: nph = sd ? 6 : (age == dur(1) - 1) ? 2 : 1;
            2: nph = sd ? 5 : (age == dur(2) - 1) ? 3 : 2;
            3: if (sd) nph = 4;
            default: if (age == dur(ph) - 1) nph = (ph == 6) ? 0 : ph + 1;
        endcase
        if (nph != 3) mblank = 1'b1;
        else if (ph == 3 && vsync && !prev_v) mblank = 1'b0;
        age = (nph != ph) ? 0 : age + 1;
        prev_v = vsync;
        ph = nph;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("state", {5'd0, state}, 8'(ph));
        chk("panel_vdd_en", {7'd0, panel_vdd_en}, {7'd0, (ph >= 1 && ph <= 5)});
        chk("lvds_en", {7'd0, lvds_en}, {7'd0, (ph >= 2 && ph <= 4)});
        chk("bl_en", {7'd0, bl_en}, {7'd0, (ph == 3)});
        chk("blank", {7'd0, blank}, {7'd0, mblank});
        chk("ready", {7'd0, ready}, {7'd0, (ph == 3 && !mblank)});
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic run_until(input int target);
        int n;
        n = 0;
        while (ph != target && n < 100) begin
            step();
            n++;
        end
        checks++;
        assert (ph == target) else begin
            errors++;
            $error("FAIL reach_phase: observed=%0d expected=%0d", ph, target);
        end
    endtask

    initial begin
        // Reset asserted between edges, held, then released with enable low
        #2 rst = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        check_all();
        rst = 1'b1;
        repeat (3) step();

        // Power-up, then first vsync rising edge unblanks
        enable = 1'b1;
        pll_locked = 1'b1;
        repeat (15) step();
        vsync = 1'b1;
        step();
        repeat (2) step();
        vsync = 1'b0;
        step();

        // Power-down; re-raised enable is ignored until OFF
        enable = 1'b0;
        repeat (9) step();
        enable = 1'b1;
        repeat (10) step();

        // Lock lost in the second cycle of LVDS_UP
        run_until(2);
        step();
        pll_locked = 1'b0;
        repeat (20) step();

        // vsync already high on ON entry is not an edge
        pll_locked = 1'b1;
        vsync = 1'b1;
        run_until(3);
        repeat (5) step();
        vsync = 1'b0;
        step();
        vsync = 1'b1;
        repeat (2) step();

        // Random enable / lock / vsync traffic
        repeat (400) begin
            enable = ($urandom_range(0, 15) != 0);
            pll_locked = ($urandom_range(0, 31) != 0);
            vsync = 1'($urandom_range(0, 1));
            step();
        end

        // Async reset mid-ON takes effect before the next clock edge
        enable = 1'b1;
        pll_locked = 1'b1;
        vsync = 1'b0;
        run_until(3);
        step();
        #2 rst = 1'b0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        check_all();
        rst = 1'b1;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
